// File: rtl/reel_pkg.sv
// Shared types and constants for the reel spinner.
package reel_pkg;

    typedef logic [1:0] rot_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPIN,
        ST_DECEL,
        ST_LAND,
        ST_DONE
    } reel_state_t;

    localparam logic [7:0] LFSR_SEED = 8'h1D;
    // Taps 8,6,5,4 expressed as a bit mask over lfsr[7:0]
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] value);
        return {value[6:0], ^(value & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/vsync_edge.sv
// Registers vsync and emits a one-cycle frame_tick on each rising edge.
module vsync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic frame_tick
);

    logic vsync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            frame_tick <= vsync & ~vsync_q;
        end
    end

endmodule

// File: rtl/reel_spinner.sv
// Slot reel sequencer: fast spin, decelerate, then land on a target rotation.
// Optional REEL_LFSR_EN: land target comes from an internal free-running LFSR.
//
// state    | meaning
// IDLE     | waiting for start, rot_state held
// SPIN     | advancing at FAST_PERIOD for SPIN_STEPS advances
// DECEL    | period grows by PERIOD_INC after each advance
// LAND     | advancing at frozen period until rot_state == target
// DONE     | one-cycle done pulse
module reel_spinner
    import reel_pkg::*;
#(
    parameter int FAST_PERIOD = 2,
    parameter int SPIN_STEPS  = 8,
    parameter int DECEL_STEPS = 3,
    parameter int PERIOD_INC  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       start,
    input  logic [1:0] target,
    output logic [1:0] rot_state,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] FAST_P  = 8'(FAST_PERIOD);
    localparam logic [7:0] INC_P   = 8'(PERIOD_INC);
    localparam logic [7:0] SPIN_N  = 8'(SPIN_STEPS);
    localparam logic [7:0] DECEL_N = 8'(DECEL_STEPS);

    reel_state_t state, state_nx;
    rot_t        rot_q, rot_nx, tgt_q, tgt_nx, start_tgt;
    logic [7:0]  frame_cnt, frame_nx, step_cnt, step_nx, period, period_nx;
    logic        frame_tick, wrap;

    vsync_edge u_vsync_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

`ifdef REEL_LFSR_EN
    logic [7:0] lfsr;
    logic       unused_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= lfsr_next(lfsr);
    end

    assign start_tgt     = lfsr[1:0];
    assign unused_target = ^target;
`else
    assign start_tgt = target;
`endif

    assign wrap = frame_tick && (frame_cnt == period - 8'd1);

    always_comb begin
        state_nx  = state;
        rot_nx    = rot_q;
        tgt_nx    = tgt_q;
        frame_nx  = frame_cnt;
        step_nx   = step_cnt;
        period_nx = period;
        case (state)
            ST_IDLE: begin
                // A tick arriving with start is dropped: counters restart from zero
                if (start) begin
                    tgt_nx    = start_tgt;
                    frame_nx  = '0;
                    step_nx   = '0;
                    period_nx = FAST_P;
                    state_nx  = ST_SPIN;
                end
            end
            ST_SPIN, ST_DECEL: begin
                if (wrap) begin
                    rot_nx   = rot_q + 2'd1;
                    frame_nx = '0;
                    step_nx  = step_cnt + 8'd1;
                    if (state == ST_SPIN) begin
                        if (step_nx == SPIN_N) begin
                            state_nx  = ST_DECEL;
                            step_nx   = '0;
                            period_nx = sat_add(FAST_P, INC_P);
                        end
                    end else if (step_nx == DECEL_N) begin
                        // Period freezes here for the whole LAND phase
                        state_nx = ST_LAND;
                        step_nx  = '0;
                    end else begin
                        period_nx = sat_add(period, INC_P);
                    end
                end else if (frame_tick) begin
                    frame_nx = frame_cnt + 8'd1;
                end
            end
            ST_LAND: begin
                if (rot_q == tgt_q) begin
                    state_nx = ST_DONE;
                end else if (wrap) begin
                    rot_nx   = rot_q + 2'd1;
                    frame_nx = '0;
                end else if (frame_tick) begin
                    frame_nx = frame_cnt + 8'd1;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rot_q     <= '0;
            tgt_q     <= '0;
            frame_cnt <= '0;
            step_cnt  <= '0;
            period    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            rot_q     <= rot_nx;
            tgt_q     <= tgt_nx;
            frame_cnt <= frame_nx;
            step_cnt  <= step_nx;
            period    <= period_nx;
            busy      <= (state_nx != ST_IDLE);
            done      <= (state_nx == ST_DONE);
        end
    end

    assign rot_state = rot_q;

endmodule

// File: doc/reel_spinner.md
REEL_SPINNER -- requirements
Module: reel_spinner

Interface
REQ-001 SHALL have parameter FAST_PERIOD, default 2, frames per symbol advance during SPIN.
REQ-002 SHALL have parameter SPIN_STEPS, default 8, number of advances in SPIN.
REQ-003 SHALL have parameter DECEL_STEPS, default 3, number of advances in DECEL.
REQ-004 SHALL have parameter PERIOD_INC, default 2, frames added to the period per DECEL advance.
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port vsync, input, 1, VGA vertical sync level, synchronous to clk.
REQ-008 SHALL have port start, input, 1, one-cycle spin request.
REQ-009 SHALL have port target, input, 2, landing rot_state, sampled on an accepted start.
REQ-010 SHALL have port rot_state, output, 2, rotation state fed to the symbol renderer.
REQ-011 SHALL have port busy, output, 1, high in SPIN, DECEL, LAND and DONE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when the reel lands.

Function
REQ-013 SHALL derive frame_tick as a one-cycle pulse on each vsync rising edge, registered, with 1-cycle latency.
REQ-014 SHALL implement FSM IDLE, SPIN, DECEL, LAND, DONE.
REQ-015 SHALL accept start only in IDLE: latch target, clear frame and step counters, set period = FAST_PERIOD, go to SPIN; start while busy SHALL be ignored.
REQ-016 SHALL advance when frame_cnt == period-1 on a frame_tick: rot_state += 1 mod 4 (3 wraps to 0), frame_cnt cleared; otherwise frame_tick increments frame_cnt (8 bits).
REQ-017 SPIN SHALL go to DECEL after SPIN_STEPS advances, with period = FAST_PERIOD + PERIOD_INC at the transition.
REQ-018 DECEL SHALL add PERIOD_INC to period after each advance; the period is 8 bits and SHALL saturate at 255. After DECEL_STEPS advances, the FSM SHALL go to LAND.
REQ-019 LAND SHALL go to DONE in the cycle it observes rot_state == latched target, including on the entry cycle; otherwise it SHALL keep advancing at the frozen period.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE; rot_state SHALL hold in IDLE and DONE.
REQ-021 A start and a frame_tick in the same IDLE cycle: the start SHALL win and the tick SHALL not be counted.
REQ-022 Outputs SHALL be registered, with no combinational path from inputs.

Reset
REQ-023 On rst_n low, the block SHALL asynchronously set: state IDLE, rot_state 0, busy 0, done 0, all counters 0, vsync history 0, LFSR seed 8'h1D.
REQ-024 Reset asserted mid-spin SHALL abort the spin with no done pulse.

Configuration
REQ-025 With REEL_LFSR_EN defined, the block SHALL run a free-running 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'h1D) that advances every clk; an accepted start SHALL latch LFSR[1:0] as target, and the target port SHALL be ignored.
REQ-026 Without REEL_LFSR_EN, the block SHALL contain no LFSR and SHALL latch the target port.

Structure
REQ-027 Package reel_pkg SHALL hold: typedef rot_t (logic [1:0]), enum reel_state_t, LFSR_SEED, LFSR_TAPS.
REQ-028 Sub-module vsync_edge SHALL implement the vsync register and rising-edge pulse.

Verification
REQ-029 Reset, rot_state=0, start with target=2 -> busy the next cycle; rot_state sequence 1,2,3,0,1,2,3,0 (SPIN), 1,2,3 (DECEL, 4/6/8 frames), 0,1,2 (LAND, 8 frames each); done pulses once after the 58th vsync rising edge.
REQ-030 Start with target=3 from rot_state 0 -> LAND matches on entry with zero LAND advances; done after 34 frames.
REQ-031 Second start pulse issued mid-SPIN -> ignored; counters and done timing identical to REQ-029.
REQ-032 rst_n low during DECEL -> rot_state=0 and busy=0 immediately; no done pulse; a new start then runs normally.
REQ-033 start coincident with frame_tick in IDLE -> frame_cnt stays 0; first advance after exactly FAST_PERIOD further ticks.
REQ-034 With REEL_LFSR_EN defined: start 3 cycles after reset -> landing rot_state equals the model LFSR[1:0] at that cycle, independent of target.
